// File: rtl/snapshot_capture_if.sv
// Sample stream from the lane aligner plus the snapshot buffer write port.
// The capture block takes the slave view; the upstream/buffer side takes the master view.
interface snapshot_capture_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_aligned;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;

  modport master (
    output in_valid, in_data, in_aligned,
    input  buf_wr_en, buf_wr_addr, buf_wr_data
  );

  modport slave (
    input  in_valid, in_data, in_aligned,
    output buf_wr_en, buf_wr_addr, buf_wr_data
  );
endinterface

// File: rtl/snapshot_capture.sv
// Arms on a stream_enable rising edge and writes up to snap_len aligned samples into the
// snapshot buffer. Define SNAP_TRIGGER_EN to add trig_in and gate the start of capture on it.
module snapshot_capture #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stream_enable,
  input  logic [LEN_W-1:0]  snap_len,
`ifdef SNAP_TRIGGER_EN
  input  logic              trig_in,
`endif
  snapshot_capture_if.slave sif,
  output logic              snapshot_done,
  output logic              capture_busy,
  output logic [LEN_W-1:0]  samples_captured,
  output logic              len_clamped
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1) << ADDR_W;

  state_t           state, state_nxt;
  logic             en_q;
  logic             rise;
  logic             start;
  logic             last;
  logic             accept;
  logic [LEN_W-1:0] eff_len;

  assign rise = stream_enable & ~en_q;
  assign last = (samples_captured + LEN_W'(1)) == eff_len;

`ifdef SNAP_TRIGGER_EN
  assign start = sif.in_aligned & trig_in;
`else
  assign start = sif.in_aligned;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE:
        if (rise) state_nxt = (snap_len == '0) ? DONE : ARM;
      ARM:
        if (!stream_enable) state_nxt = IDLE;
        else if (start) begin
          state_nxt = CAPTURE;
`ifdef SNAP_TRIGGER_EN
          // the sample that arrives with the trigger is sample 0
          if (sif.in_valid) begin
            accept = 1'b1;
            if (last) state_nxt = DONE;
          end
`endif
        end
      CAPTURE:
        if (!stream_enable) state_nxt = IDLE;
        else if (sif.in_valid && sif.in_aligned) begin
          accept = 1'b1;
          if (last) state_nxt = DONE;
        end
      DONE:
        if (!stream_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      en_q             <= 1'b0;
      eff_len          <= '0;
      len_clamped      <= 1'b0;
      samples_captured <= '0;
      snapshot_done    <= 1'b0;
      capture_busy     <= 1'b0;
      sif.buf_wr_en    <= 1'b0;
      sif.buf_wr_addr  <= '0;
      sif.buf_wr_data  <= '0;
    end else begin
      state         <= state_nxt;
      en_q          <= stream_enable;
      snapshot_done <= (state_nxt == DONE);
      capture_busy  <= (state_nxt == ARM) || (state_nxt == CAPTURE);
      sif.buf_wr_en <= accept;
      if (accept) begin
        sif.buf_wr_addr  <= samples_captured[ADDR_W-1:0];
        sif.buf_wr_data  <= sif.in_data;
        samples_captured <= samples_captured + LEN_W'(1);
      end
      // length is latched once per arm; later snap_len writes wait for the next edge
      if (state == IDLE && rise) begin
        eff_len          <= (snap_len > DEPTH) ? DEPTH : snap_len;
        len_clamped      <= (snap_len > DEPTH);
        samples_captured <= '0;
      end
    end
  end

endmodule

// File: tb/tb_snapshot_capture.sv
// Randomized bench for snapshot_capture with a transaction-level reference model.
// Build with SNAP_TRIGGER_EN defined to exercise the trigger variant.
module tb_snapshot_capture;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
`ifdef SNAP_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic             clk, rst, stream_enable, trig_in;
  logic [LEN_W-1:0] snap_len;
  logic             snapshot_done, capture_busy, len_clamped;
  logic [LEN_W-1:0] samples_captured;

  int checks = 0;
  int errors = 0;

  snapshot_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

  snapshot_capture #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stream_enable    (stream_enable),
    .snap_len         (snap_len),
`ifdef SNAP_TRIGGER_EN
    .trig_in          (trig_in),
`endif
    .sif              (sif),
    .snapshot_done    (snapshot_done),
    .capture_busy     (capture_busy),
    .samples_captured (samples_captured),
    .len_clamped      (len_clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase 0 idle, 1 armed, 2 capturing, 3 complete
  int     m_phase, m_cnt;
  longint m_target;
  bit     m_prev, m_done, m_busy, m_clamp, m_take;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] act_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_prev = 1'b0; m_cnt = 0; m_clamp = 1'b0; m_target = 0;
    end else begin
      m_take = 1'b0;
      if (m_phase != 0 && !stream_enable) m_phase = 0;
      else case (m_phase)
        0: if (stream_enable && !m_prev) begin
             m_target = (snap_len > DEPTH) ? DEPTH : longint'(snap_len);
             m_clamp  = snap_len > DEPTH;
             m_cnt    = 0;
             m_phase  = (snap_len == 0) ? 3 : 1;
           end
        1: if (sif.in_aligned && (!TRIG || trig_in)) begin
             m_phase = 2;
             m_take  = TRIG && sif.in_valid;
           end
        2: m_take = sif.in_valid && sif.in_aligned;
        default: ;
      endcase
      if (m_take) begin
        exp_q.push_back({m_cnt[ADDR_W-1:0], sif.in_data});
        m_cnt++;
        if (m_cnt == m_target) m_phase = 3;
      end
      m_prev = stream_enable;
    end
    m_done = (m_phase == 3);
    m_busy = (m_phase == 1) || (m_phase == 2);
  end

  always @(posedge clk) begin
    #1;
    if (sif.buf_wr_en === 1'b1) act_q.push_back({sif.buf_wr_addr, sif.buf_wr_data});
  end

  // drive one cycle of inputs, let the edge pass, return with outputs settled
  task automatic cyc(input bit e, input logic [LEN_W-1:0] l, input bit v, input bit a, input bit t);
    stream_enable  = e;
    snap_len       = l;
    sif.in_valid   = v;
    sif.in_aligned = a;
    sif.in_data    = DATA_W'($urandom);
    trig_in        = t;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if ({sif.buf_wr_en, snapshot_done, capture_busy, len_clamped} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=0000", {sif.buf_wr_en, snapshot_done, capture_busy, len_clamped}); end
    checks++; if (samples_captured !== '0)
      begin errors++; $display("FAIL reset_count got=%0d exp=0", samples_captured); end
    checks++; if ({sif.buf_wr_addr, sif.buf_wr_data} !== '0)
      begin errors++; $display("FAIL reset_bus got=%h exp=0", {sif.buf_wr_addr, sif.buf_wr_data}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    idle(2);
    for (int c = 0; c < 14; c++) begin
      cyc(1'b1, 32'd8, 1'b1, 1'b1, 1'b1);
      checks++; if ({snapshot_done, capture_busy} !== {m_done, m_busy})
        begin errors++; $display("FAIL basic_flags c=%0d got=%b exp=%b", c, {snapshot_done, capture_busy}, {m_done, m_busy}); end
      if (sif.buf_wr_en === 1'b1 && sif.buf_wr_addr === 12'd7) begin
        checks++; if (snapshot_done !== 1'b1)
          begin errors++; $display("FAIL basic_done_with_last got=%b exp=1", snapshot_done); end
      end
    end
    checks++; if (act_q.size() != 8)
      begin errors++; $display("FAIL basic_count got=%0d exp=8", act_q.size()); end
    foreach (act_q[i]) begin
      checks++; if (act_q[i][ADDR_W+DATA_W-1:DATA_W] !== ADDR_W'(i) || i >= exp_q.size() || act_q[i] !== exp_q[i])
        begin errors++; $display("FAIL basic_write i=%0d got=%h exp_addr=%0d", i, act_q[i], i); end
    end
    checks++; if (samples_captured !== 32'd8 || snapshot_done !== 1'b1)
      begin errors++; $display("FAIL basic_final got=%0d/%b exp=8/1", samples_captured, snapshot_done); end
    cyc(1'b0, 32'd8, 1'b1, 1'b1, 1'b1);
    checks++; if (snapshot_done !== 1'b0 || samples_captured !== 32'd8)
      begin errors++; $display("FAIL basic_release got=%b/%0d exp=0/8", snapshot_done, samples_captured); end
  endtask

  task automatic test_zero_len;
    idle(2);
    cyc(1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
    checks++; if ({snapshot_done, capture_busy} !== 2'b10)
      begin errors++; $display("FAIL zero_done got=%b exp=10", {snapshot_done, capture_busy}); end
    repeat (5) cyc(1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
    checks++; if (act_q.size() != 0 || samples_captured !== '0 || snapshot_done !== 1'b1)
      begin errors++; $display("FAIL zero_writes got=%0d/%0d/%b exp=0/0/1", act_q.size(), samples_captured, snapshot_done); end
  endtask

  task automatic test_clamp;
    idle(2);
    repeat (4110) cyc(1'b1, 32'd5000, 1'b1, 1'b1, 1'b1);
    checks++; if (len_clamped !== 1'b1)
      begin errors++; $display("FAIL clamp_flag got=%b exp=1", len_clamped); end
    checks++; if (act_q.size() != DEPTH || samples_captured !== 32'd4096 || snapshot_done !== 1'b1)
      begin errors++; $display("FAIL clamp_count got=%0d/%0d/%b exp=4096/4096/1", act_q.size(), samples_captured, snapshot_done); end
    foreach (act_q[i]) begin
      checks++; if (act_q[i][ADDR_W+DATA_W-1:DATA_W] !== ADDR_W'(i) || i >= exp_q.size() || act_q[i] !== exp_q[i])
        begin errors++; $display("FAIL clamp_write i=%0d got=%h", i, act_q[i]); end
    end
  endtask

  task automatic test_misalign;
    idle(2);
    repeat (7) cyc(1'b1, 32'd16, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 32'd16, 1'b1, 1'b0, 1'b1);
    checks++; if (act_q.size() != exp_q.size() || capture_busy !== 1'b1)
      begin errors++; $display("FAIL misalign_hold got=%0d/%b exp=%0d/1", act_q.size(), capture_busy, exp_q.size()); end
    repeat (20) cyc(1'b1, 32'd16, 1'b1, 1'b1, 1'b1);
    checks++; if (act_q.size() != 16 || samples_captured !== 32'd16 || snapshot_done !== 1'b1)
      begin errors++; $display("FAIL misalign_count got=%0d/%0d/%b exp=16/16/1", act_q.size(), samples_captured, snapshot_done); end
    foreach (act_q[i]) begin
      checks++; if (act_q[i][ADDR_W+DATA_W-1:DATA_W] !== ADDR_W'(i) || i >= exp_q.size() || act_q[i] !== exp_q[i])
        begin errors++; $display("FAIL misalign_write i=%0d got=%h", i, act_q[i]); end
    end
  endtask

  task automatic test_abort;
    idle(2);
    for (int c = 0; c < 50 && act_q.size() < 4; c++) cyc(1'b1, 32'd16, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'd16, 1'b1, 1'b1, 1'b1);
    checks++; if (act_q.size() != 4 || samples_captured !== 32'd4)
      begin errors++; $display("FAIL abort_count got=%0d/%0d exp=4/4", act_q.size(), samples_captured); end
    checks++; if ({snapshot_done, capture_busy} !== 2'b00)
      begin errors++; $display("FAIL abort_flags got=%b exp=00", {snapshot_done, capture_busy}); end
    idle(1);
    repeat (12) cyc(1'b1, 32'd6, 1'b1, 1'b1, 1'b1);
    checks++; if (act_q.size() != 6 || samples_captured !== 32'd6)
      begin errors++; $display("FAIL rearm_count got=%0d/%0d exp=6/6", act_q.size(), samples_captured); end
    foreach (act_q[i]) begin
      checks++; if (act_q[i][ADDR_W+DATA_W-1:DATA_W] !== ADDR_W'(i) || i >= exp_q.size() || act_q[i] !== exp_q[i])
        begin errors++; $display("FAIL rearm_write i=%0d got=%h", i, act_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    idle(2);
    repeat (4) cyc(1'b1, 32'd10, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 32'd10, 1'b1, 1'b1, 1'b1);
    checks++; if ({sif.buf_wr_en, capture_busy, snapshot_done} !== 3'b000 || samples_captured !== '0)
      begin errors++; $display("FAIL reset_mid got=%b/%0d exp=000/0", {sif.buf_wr_en, capture_busy, snapshot_done}, samples_captured); end
    rst = 1'b0;
    idle(2);
  endtask

`ifdef SNAP_TRIGGER_EN
  task automatic test_trigger;
    logic [DATA_W-1:0] d0;
    idle(2);
    repeat (20) cyc(1'b1, 32'd10, 1'b1, 1'b1, 1'b0);
    checks++; if (act_q.size() != 0 || capture_busy !== 1'b1)
      begin errors++; $display("FAIL trig_wait got=%0d/%b exp=0/1", act_q.size(), capture_busy); end
    cyc(1'b1, 32'd10, 1'b1, 1'b1, 1'b1);
    d0 = sif.in_data;
    repeat (3) cyc(1'b1, 32'd10, 1'b1, 1'b1, 1'b0);
    checks++; if (act_q.size() < 1 || act_q[0] !== {12'd0, d0})
      begin errors++; $display("FAIL trig_first got=%h exp=%h", (act_q.size() > 0) ? act_q[0] : 'x, {12'd0, d0}); end
    checks++; if (act_q.size() != 4)
      begin errors++; $display("FAIL trig_count got=%0d exp=4", act_q.size()); end
  endtask
`endif

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      int unsigned len;
      bit aborted;
      idle(2);
      len = $urandom_range(0, 40);
      aborted = 1'b0;
      for (int c = 0; c < 90 && !aborted; c++) begin
        aborted = ($urandom_range(0, 99) < 2);
        cyc(!aborted, (c == 0) ? len : $urandom_range(0, 5000), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
        checks++; if ({snapshot_done, capture_busy, len_clamped} !== {m_done, m_busy, m_clamp} || samples_captured !== LEN_W'(m_cnt))
          begin errors++; $display("FAIL rand_state it=%0d c=%0d got=%b/%0d exp=%b/%0d", it, c,
            {snapshot_done, capture_busy, len_clamped}, samples_captured, {m_done, m_busy, m_clamp}, m_cnt); end
      end
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (act_q.size() != exp_q.size())
        begin errors++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, act_q.size(), exp_q.size()); end
      foreach (act_q[i]) begin
        checks++; if (i >= exp_q.size() || act_q[i] !== exp_q[i])
          begin errors++; $display("FAIL rand_write it=%0d i=%0d got=%h", it, i, act_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    test_clamp;
    test_misalign;
    test_abort;
    test_reset_mid;
`ifdef SNAP_TRIGGER_EN
    test_trigger;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
